// File: rtl/cluster_pkg.sv
// Shared types and constants for the cluster frame collector.
package cluster_pkg;

   localparam int unsigned MXADRBITS = 11;
   localparam int unsigned MXCNTBITS = 3;
   localparam int unsigned CLUSTER_W = MXADRBITS + MXCNTBITS;

   localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;

   typedef struct packed {
      logic [MXCNTBITS-1:0] cnt;
      logic [MXADRBITS-1:0] adr;
   } cluster_t;

   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } state_t;

   // Empty slot marker: zero size, all-ones address.
   function automatic cluster_t invalid_cluster();
      cluster_t c;
      c.cnt = '0;
      c.adr = INVALID_ADR;
      return c;
   endfunction

endpackage

// File: rtl/cluster_slot_writer.sv
// One-hot slot write-enable decode from the fill pointer, plus overflow
// detect when a cluster arrives with every slot already taken.
module cluster_slot_writer #(
   parameter int unsigned MXCLUSTERS = 8,
   parameter int unsigned PTR_W      = 4
) (
   input  logic                  i_sample,
   input  logic                  i_found,
   input  logic [PTR_W-1:0]      i_ptr,
   output logic [MXCLUSTERS-1:0] o_we,
   output logic                  o_ovf
);

   logic w_room;
   logic w_write;

   assign w_room  = (i_ptr < PTR_W'(MXCLUSTERS));
   assign w_write = i_sample & i_found;

   // Decode the pointer into a single slot enable.
   always_comb begin
      o_we = '0;
      for (int unsigned i = 0; i < MXCLUSTERS; i++) begin
         o_we[i] = w_write & w_room & (i_ptr == PTR_W'(i));
      end
   end

   assign o_ovf = w_write & ~w_room;

endmodule

// File: rtl/cluster_frame_collector.sv
// Collects per-clock encoder clusters into one frame per bunch crossing.
// Optional output nclusters is enabled by defining CLUSTER_COUNT_EN.
module cluster_frame_collector
   import cluster_pkg::*;
#(
   parameter int unsigned MXCLUSTERS = 8,
   parameter int unsigned BX_CLOCKS  = 4
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            bx_start,
   input  logic                            cluster_found,
   input  logic [MXADRBITS-1:0]            adr,
   input  logic [MXCNTBITS-1:0]            cnt,
   output logic                            frame_valid,
   output logic [MXCLUSTERS*CLUSTER_W-1:0] frame,
   output logic                            overflow,
   output logic                            sync_err
`ifdef CLUSTER_COUNT_EN
   ,
   output logic [$clog2(MXCLUSTERS+1)-1:0] nclusters
`endif
);

   localparam int unsigned PTR_W = $clog2(MXCLUSTERS + 1);
   localparam int unsigned CYC_W = $clog2(BX_CLOCKS + 1);

   state_t                      r_state;
   logic [CYC_W-1:0]            r_cyc;
   logic                        r_frame_valid;
   logic                        r_sync_err;
   cluster_t                    r_buf [MXCLUSTERS];
   logic [PTR_W-1:0]            r_ptr;
   logic                        r_ovf;
   logic [MXCLUSTERS*CLUSTER_W-1:0] r_frame;
   logic                        r_overflow;
`ifdef CLUSTER_COUNT_EN
   logic [PTR_W-1:0]            r_ncl;
`endif

   logic                  w_emit;
   logic                  w_in_window;
   logic                  w_early;
   logic                  w_sample;
   logic [PTR_W-1:0]      w_ptr_base;
   logic [MXCLUSTERS-1:0] w_we;
   logic                  w_ovf;
   cluster_t              w_in;

   // COLLECT lasts BX_CLOCKS cycles: window cycles 1..BX_CLOCKS-1 sample the
   // encoder, the final cycle (r_cyc == BX_CLOCKS) only emits, so a bx_start
   // there is a clean back-to-back start rather than an early restart.
   assign w_emit      = (r_state == ST_COLLECT) && (r_cyc == CYC_W'(BX_CLOCKS));
   assign w_in_window = (r_state == ST_COLLECT) && !w_emit;
   assign w_early     = bx_start && w_in_window;
   assign w_sample    = bx_start || w_in_window;
   assign w_ptr_base  = bx_start ? '0 : r_ptr;
   assign w_in        = {cnt, adr};

   cluster_slot_writer #(
      .MXCLUSTERS (MXCLUSTERS),
      .PTR_W      (PTR_W)
   ) u_slot_writer (
      .i_sample (w_sample),
      .i_found  (cluster_found),
      .i_ptr    (w_ptr_base),
      .o_we     (w_we),
      .o_ovf    (w_ovf)
   );

   // Window sequencing, frame_valid pulse and sticky sync error.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_cyc         <= '0;
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_frame_valid <= w_emit;
         if (w_early) begin
            r_sync_err <= 1'b1;
         end
         if (bx_start) begin
            r_state <= ST_COLLECT;
            r_cyc   <= CYC_W'(1);
         end else if (r_state == ST_COLLECT) begin
            if (w_emit) begin
               r_state <= ST_IDLE;
               r_cyc   <= '0;
            end else begin
               r_cyc <= r_cyc + CYC_W'(1);
            end
         end
      end
   end

   // Working buffer: cleared and written in the same edge at window start.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MXCLUSTERS; i++) begin
            r_buf[i] <= invalid_cluster();
         end
         r_ptr <= '0;
         r_ovf <= 1'b0;
      end else if (w_sample) begin
         for (int unsigned i = 0; i < MXCLUSTERS; i++) begin
            if (w_we[i]) begin
               r_buf[i] <= w_in;
            end else if (bx_start) begin
               r_buf[i] <= invalid_cluster();
            end
         end
         r_ptr <= w_ptr_base + PTR_W'(|w_we);
         r_ovf <= (bx_start ? 1'b0 : r_ovf) | w_ovf;
      end
   end

   // Output frame register, loaded only on emission and held otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MXCLUSTERS; i++) begin
            r_frame[i*CLUSTER_W +: CLUSTER_W] <= invalid_cluster();
         end
         r_overflow <= 1'b0;
`ifdef CLUSTER_COUNT_EN
         r_ncl <= '0;
`endif
      end else if (w_emit) begin
         for (int unsigned i = 0; i < MXCLUSTERS; i++) begin
            r_frame[i*CLUSTER_W +: CLUSTER_W] <= r_buf[i];
         end
         r_overflow <= r_ovf;
`ifdef CLUSTER_COUNT_EN
         r_ncl <= r_ptr;
`endif
      end
   end

   assign frame_valid = r_frame_valid;
   assign frame       = r_frame;
   assign overflow    = r_overflow;
   assign sync_err    = r_sync_err;
`ifdef CLUSTER_COUNT_EN
   assign nclusters   = r_ncl;
`endif

endmodule

// File: tb/tb_cluster_frame_collector.sv
// Directed bench for cluster_frame_collector: three instances (8, 4 and 2
// slots) share one stimulus stream; expected frames are hand-built.
module tb_cluster_frame_collector;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        bx_start = 1'b0;
   logic        found = 1'b0;
   logic [10:0] adr = 11'h7FF;
   logic [2:0]  cnt = 3'd0;

   logic         fv8, ov8, se8;
   logic [111:0] fr8;
   logic         fv4, ov4, se4;
   logic [55:0]  fr4;
   logic         fv2, ov2, se2;
   logic [27:0]  fr2;
`ifdef CLUSTER_COUNT_EN
   logic [3:0]   ncl8;
   logic [2:0]   ncl4;
   logic [1:0]   ncl2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   cluster_frame_collector u_dut8 (
      .clock (clock), .reset_n (reset_n), .bx_start (bx_start),
      .cluster_found (found), .adr (adr), .cnt (cnt),
      .frame_valid (fv8), .frame (fr8), .overflow (ov8), .sync_err (se8)
`ifdef CLUSTER_COUNT_EN
      , .nclusters (ncl8)
`endif
   );

   cluster_frame_collector #(.MXCLUSTERS(4), .BX_CLOCKS(4)) u_dut4 (
      .clock (clock), .reset_n (reset_n), .bx_start (bx_start),
      .cluster_found (found), .adr (adr), .cnt (cnt),
      .frame_valid (fv4), .frame (fr4), .overflow (ov4), .sync_err (se4)
`ifdef CLUSTER_COUNT_EN
      , .nclusters (ncl4)
`endif
   );

   cluster_frame_collector #(.MXCLUSTERS(2), .BX_CLOCKS(4)) u_dut2 (
      .clock (clock), .reset_n (reset_n), .bx_start (bx_start),
      .cluster_found (found), .adr (adr), .cnt (cnt),
      .frame_valid (fv2), .frame (fr2), .overflow (ov2), .sync_err (se2)
`ifdef CLUSTER_COUNT_EN
      , .nclusters (ncl2)
`endif
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] inv(input int unsigned n);
      logic [127:0] f;
      f = '0;
      for (int unsigned i = 0; i < n; i++) f[i*14 +: 14] = {3'd0, 11'h7FF};
      return f;
   endfunction

   function automatic logic [127:0] put(input logic [127:0] f, input int unsigned slot,
                                        input logic [2:0] c, input logic [10:0] a);
      logic [127:0] r;
      r = f;
      r[slot*14 +: 14] = {c, a};
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic b, input logic f, input logic [10:0] a, input logic [2:0] c);
      bx_start = b;
      found    = f;
      adr      = a;
      cnt      = c;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 11'h7FF, 3'd0);
   endtask

   logic [127:0] e8, e4, e2;

   initial begin
      // Reset state
      idle();
      repeat (2) tick();
      check("rst_fv", 128'(fv8), 128'(1'b0));
      check("rst_ov", 128'(ov8), 128'(1'b0));
      check("rst_se", 128'(se8), 128'(1'b0));
      check("rst_fr8", 128'(fr8), inv(8));
      check("rst_fr2", 128'(fr2), inv(2));
`ifdef CLUSTER_COUNT_EN
      check("rst_ncl", 128'(ncl8), 128'(0));
`endif
      reset_n = 1'b1;
      tick();

      // Single cluster, latency BX_CLOCKS+1
      drive(1'b1, 1'b1, 11'h123, 3'd2);
      tick();
      idle();
      repeat (3) tick();
      check("t1_fv_early", 128'(fv8), 128'(1'b0));
      tick();
      check("t1_fv", 128'(fv8), 128'(1'b1));
      check("t1_fr8", 128'(fr8), put(inv(8), 0, 3'd2, 11'h123));
      check("t1_ov", 128'(ov8), 128'(1'b0));
      check("t1_fr4", 128'(fr4), put(inv(4), 0, 3'd2, 11'h123));
`ifdef CLUSTER_COUNT_EN
      check("t1_ncl", 128'(ncl8), 128'(1));
`endif
      tick();
      check("t1_fv_pulse", 128'(fv8), 128'(1'b0));
      check("t1_hold", 128'(fr8), put(inv(8), 0, 3'd2, 11'h123));

      // Full frames: found every cycle, adr 0..7 across two windows
      for (int k = 0; k < 8; k++) begin
         drive((k % 4) == 0, 1'b1, 11'(k), 3'd1);
         tick();
         if (k == 4) begin
            e8 = inv(8); e4 = inv(4); e2 = inv(2);
            for (int unsigned s = 0; s < 4; s++) begin
               e8 = put(e8, s, 3'd1, 11'(s));
               e4 = put(e4, s, 3'd1, 11'(s));
            end
            e2 = put(put(e2, 0, 3'd1, 11'd0), 1, 3'd1, 11'd1);
            check("t2a_fv4", 128'(fv4), 128'(1'b1));
            check("t2a_fr4", 128'(fr4), e4);
            check("t2a_ov4", 128'(ov4), 128'(1'b0));
            check("t2a_fr8", 128'(fr8), e8);
            check("t2a_fr2", 128'(fr2), e2);
            check("t2a_ov2", 128'(ov2), 128'(1'b1));
`ifdef CLUSTER_COUNT_EN
            check("t2a_ncl4", 128'(ncl4), 128'(4));
`endif
         end
      end
      idle();
      tick();
      e4 = inv(4);
      for (int unsigned s = 0; s < 4; s++) e4 = put(e4, s, 3'd1, 11'(s + 4));
      check("t2b_fv4", 128'(fv4), 128'(1'b1));
      check("t2b_fr4", 128'(fr4), e4);
      check("t2b_ov4", 128'(ov4), 128'(1'b0));
      check("t2b_fr2", 128'(fr2), put(put(inv(2), 0, 3'd1, 11'd4), 1, 3'd1, 11'd5));

      // Overflow: three clusters into two slots
      tick();
      drive(1'b1, 1'b1, 11'd10, 3'd1); tick();
      drive(1'b0, 1'b1, 11'd20, 3'd1); tick();
      drive(1'b0, 1'b1, 11'd30, 3'd1); tick();
      idle(); tick();
      tick();
      check("t3_fv2", 128'(fv2), 128'(1'b1));
      check("t3_fr2", 128'(fr2), put(put(inv(2), 0, 3'd1, 11'd10), 1, 3'd1, 11'd20));
      check("t3_ov2", 128'(ov2), 128'(1'b1));
      check("t3_fr4", 128'(fr4),
            put(put(put(inv(4), 0, 3'd1, 11'd10), 1, 3'd1, 11'd20), 2, 3'd1, 11'd30));
      check("t3_ov4", 128'(ov4), 128'(1'b0));
`ifdef CLUSTER_COUNT_EN
      check("t3_ncl2", 128'(ncl2), 128'(2));
      check("t3_ncl4", 128'(ncl4), 128'(3));
`endif

      // Back-to-back windows every 4 clocks
      tick();
      for (int t = 0; t < 14; t++) begin
         if ((t % 4) == 0 && t < 12) drive(1'b1, 1'b1, 11'(11'h100 + t / 4), 3'd3);
         else idle();
         tick();
         check("t4_fv", 128'(fv8), 128'(t == 4 || t == 8 || t == 12));
         if (t == 4 || t == 8 || t == 12)
            check("t4_fr8", 128'(fr8), put(inv(8), 0, 3'd3, 11'(11'h100 + t / 4 - 1)));
      end
      check("t4_se", 128'(se8), 128'(1'b0));

      // Early restart at window cycle 2
      drive(1'b1, 1'b1, 11'h050, 3'd1); tick();
      idle(); tick();
      drive(1'b1, 1'b1, 11'h060, 3'd2); tick();
      check("t5_se_set", 128'(se8), 128'(1'b1));
      idle();
      for (int j = 2; j <= 5; j++) begin
         tick();
         check("t5_fv", 128'(fv8), 128'(j == 5));
      end
      check("t5_fr8", 128'(fr8), put(inv(8), 0, 3'd2, 11'h060));
      tick();
      check("t5_se_sticky", 128'(se8), 128'(1'b1));

      // Reset mid-window
      drive(1'b1, 1'b1, 11'h070, 3'd1); tick();
      idle(); tick();
      reset_n = 1'b0;
      #1;
      check("t6_fv", 128'(fv8), 128'(1'b0));
      check("t6_se", 128'(se8), 128'(1'b0));
      check("t6_ov2", 128'(ov2), 128'(1'b0));
      check("t6_fr8", 128'(fr8), inv(8));
      repeat (2) tick();
      reset_n = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         check("t6_no_fv", 128'(fv8), 128'(1'b0));
      end
      drive(1'b1, 1'b1, 11'h077, 3'd4); tick();
      idle();
      repeat (3) tick();
      check("t6_fv_early", 128'(fv8), 128'(1'b0));
      tick();
      check("t6_fv_after", 128'(fv8), 128'(1'b1));
      check("t6_fr_after", 128'(fr8), put(inv(8), 0, 3'd4, 11'h077));
      check("t6_se_after", 128'(se8), 128'(1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
